// File: rtl/pulse_cnt_pkg.sv
// Shared types and constants for the pulse counter array: frame words,
// window/readout FSM state encodings and the frame length helper.
package pulse_cnt_pkg;

  localparam logic [9:0] HDR0_DEF = 10'h3BE;
  localparam logic [9:0] HDR1_DEF = 10'h2FB;
  localparam logic [9:0] TRL_DEF  = 10'h2BF;

  typedef enum logic [1:0] {
    WIN_IDLE  = 2'd0,
    WIN_COUNT = 2'd1,
    WIN_CLOSE = 2'd2
  } win_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

  // Two header words, one word per channel, one trailer word.
  function automatic int frame_len(input int n_ch);
    return n_ch + 3;
  endfunction

endpackage

// File: rtl/pulse_counter_array_if.sv
// Readout stream of the pulse counter array.
// A word transfers on a rising clk50 edge where rd_valid & rd_ready are both
// high; once rd_valid is raised, rd_data/rd_last hold until that transfer.
interface pulse_counter_array_if #(
  parameter int CNT_W = 10
) ();
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;
  logic             rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/pulse_cnt_chan.sv
// One channel: two-flop synchroniser, registered rising-edge detect and a
// saturating edge counter (a source edge reaches the counter 3 cycles later).
module pulse_cnt_chan #(
  parameter int CNT_W = 10
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             src,
  input  logic             count_en,
  input  logic             cnt_zero,
  output logic [CNT_W-1:0] cnt
);

  logic sync1, sync2, prev, rise_q;

  always_ff @(posedge clk50) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      rise_q <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= src;
      sync2  <= sync1;
      prev   <= sync2;
      rise_q <= sync2 & ~prev;
      if (cnt_zero)
        cnt <= '0;
      else if (count_en && rise_q && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_counter_array.sv
// Multi-channel pulse counter: windowed edge counting, snapshot handoff with
// overrun detection and a framed readout stream.
module pulse_counter_array
  import pulse_cnt_pkg::*;
#(
  parameter int               N_CH  = 50,
  parameter int               CNT_W = 10,
  parameter int               WIN_W = 24,
  parameter logic [CNT_W-1:0] HDR0  = CNT_W'(HDR0_DEF),
  parameter logic [CNT_W-1:0] HDR1  = CNT_W'(HDR1_DEF),
  parameter logic [CNT_W-1:0] TRL   = CNT_W'(TRL_DEF)
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic [N_CH-1:0]   inpulse,
  input  logic              stim_pulse,
  input  logic [N_CH-1:0]   stim_mask,
  input  logic              cnt_start,
  input  logic              cnt_clr,
  input  logic              cont_mode,
  input  logic [WIN_W-1:0]  win_len,
  output logic              cnt_busy,
  output logic              cnt_done,
  output logic              overrun,
  pulse_counter_array_if.master rd,
  output win_state_t        win_state_dbg,
  output rd_state_t         rd_state_dbg
);

  localparam int FRAME_LEN = frame_len(N_CH);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  win_state_t       win_state;
  rd_state_t        rd_state;
  logic [WIN_W-1:0] timer, win_q, eff_len;
  logic [CNT_W-1:0] cnt  [N_CH];
  logic [CNT_W-1:0] snap [N_CH];
  logic             count_en, cnt_zero, take_snap;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CH_W-1:0]  ch_sel;
  logic [CNT_W-1:0] nxt_word;
  logic             rd_valid_q, rd_last_q;
  logic [CNT_W-1:0] rd_data_q;

  assign count_en  = (win_state == WIN_COUNT);
  assign cnt_zero  = cnt_clr || (win_state == WIN_CLOSE);
  assign take_snap = (win_state == WIN_CLOSE) && (rd_state == RD_IDLE) && !cnt_clr;
  assign eff_len   = (win_len == '0) ? WIN_W'(1) : win_len;
  assign cnt_busy  = (win_state != WIN_IDLE);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    pulse_cnt_chan #(.CNT_W(CNT_W)) u_chan (
      .clk50    (clk50),
      .rst      (rst),
      .src      (inpulse[g] | (stim_pulse & stim_mask[g])),
      .count_en (count_en),
      .cnt_zero (cnt_zero),
      .cnt      (cnt[g])
    );
  end

  // Window FSM; cnt_clr pre-empts everything below rst.
  always_ff @(posedge clk50) begin
    if (rst) begin
      win_state <= WIN_IDLE;
      timer     <= '0;
      win_q     <= '0;
      overrun   <= 1'b0;
      cnt_done  <= 1'b0;
    end else begin
      cnt_done <= take_snap;
      if (cnt_clr) begin
        win_state <= WIN_IDLE;
        timer     <= '0;
        overrun   <= 1'b0;
      end else begin
        case (win_state)
          WIN_IDLE: begin
            if (cnt_start) begin
              win_state <= WIN_COUNT;
              timer     <= '0;
              win_q     <= eff_len;
            end
          end
          WIN_COUNT: begin
            if (timer == win_q - WIN_W'(1)) begin
              win_state <= WIN_CLOSE;
              timer     <= '0;
            end else begin
              timer <= timer + WIN_W'(1);
            end
          end
          WIN_CLOSE: begin
            if (rd_state != RD_IDLE)
              overrun <= 1'b1;
            timer <= '0;
            if (cont_mode) begin
              win_state <= WIN_COUNT;
              win_q     <= eff_len;
            end else begin
              win_state <= WIN_IDLE;
            end
          end
          default: win_state <= WIN_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst)
      snap <= '{default: '0};
    else if (take_snap)
      snap <= cnt;
  end

  // Next word is prepared from the index it will occupy once the current one is taken.
  assign idx_nxt = idx + IDX_W'(1);
  assign ch_sel  = CH_W'(idx_nxt - IDX_W'(2));

  always_comb begin
    nxt_word = '0;
    if (idx_nxt == IDX_W'(1))
      nxt_word = HDR1;
    else if (idx_nxt == LAST_IDX)
      nxt_word = TRL;
    else
      nxt_word = snap[ch_sel];
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      idx        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (take_snap) begin
            rd_state   <= RD_SEND;
            idx        <= '0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= HDR0;
            rd_last_q  <= 1'b0;
          end
        end
        RD_SEND: begin
          if (rd.rd_ready) begin
            if (rd_last_q) begin
              rd_state   <= RD_IDLE;
              idx        <= '0;
              rd_valid_q <= 1'b0;
              rd_data_q  <= '0;
              rd_last_q  <= 1'b0;
            end else begin
              idx       <= idx_nxt;
              rd_data_q <= nxt_word;
              rd_last_q <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign rd.rd_valid    = rd_valid_q;
  assign rd.rd_data     = rd_data_q;
  assign rd.rd_last     = rd_last_q;
  assign win_state_dbg  = win_state;
  assign rd_state_dbg   = rd_state;

endmodule

// File: tb/tb_pulse_counter_array.sv
// Directed bench for pulse_counter_array: a 4-channel 10-bit instance plus a
// 4-bit instance driven in parallel for saturation.
module tb_pulse_counter_array;
  import pulse_cnt_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 10;
  localparam int SAT_W = 4;
  localparam int WIN_W = 24;

  logic              clk50 = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   inpulse;
  logic              stim_pulse;
  logic [N_CH-1:0]   stim_mask;
  logic              cnt_start, cnt_clr, cont_mode;
  logic [WIN_W-1:0]  win_len;
  logic              rd_ready;
  logic              cnt_busy, cnt_done, overrun;
  logic              s_busy, s_done, s_overrun;
  win_state_t        w_dbg, s_w_dbg;
  rd_state_t         r_dbg, s_r_dbg;

  pulse_counter_array_if #(.CNT_W(CNT_W)) rd_if ();
  pulse_counter_array_if #(.CNT_W(SAT_W)) sat_if ();
  assign rd_if.rd_ready  = rd_ready;
  assign sat_if.rd_ready = rd_ready;

  pulse_counter_array #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) u_dut (
    .clk50(clk50), .rst(rst), .inpulse(inpulse), .stim_pulse(stim_pulse),
    .stim_mask(stim_mask), .cnt_start(cnt_start), .cnt_clr(cnt_clr),
    .cont_mode(cont_mode), .win_len(win_len), .cnt_busy(cnt_busy),
    .cnt_done(cnt_done), .overrun(overrun), .rd(rd_if.master),
    .win_state_dbg(w_dbg), .rd_state_dbg(r_dbg)
  );

  pulse_counter_array #(.N_CH(N_CH), .CNT_W(SAT_W), .WIN_W(WIN_W)) u_sat (
    .clk50(clk50), .rst(rst), .inpulse(inpulse), .stim_pulse(stim_pulse),
    .stim_mask(stim_mask), .cnt_start(cnt_start), .cnt_clr(cnt_clr),
    .cont_mode(cont_mode), .win_len(win_len), .cnt_busy(s_busy),
    .cnt_done(s_done), .overrun(s_overrun), .rd(sat_if.master),
    .win_state_dbg(s_w_dbg), .rd_state_dbg(s_r_dbg)
  );

  // Clock / watchdog
  always #10 clk50 = ~clk50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [CNT_W:0] exp_q[$];
  logic [CNT_W:0] mon_q[$];
  logic [SAT_W:0] sat_q[$];
  int             done_cnt = 0;
  logic           done_busy = 1'b0;
  logic           prev_stall = 1'b0;
  logic [CNT_W:0] prev_word = '0;
  logic           rand_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: records accepted words and checks stall stability.
  always @(negedge clk50) begin
    if (cnt_done) begin
      done_cnt++;
      done_busy = cnt_busy;
    end
    if (prev_stall && rd_if.rd_valid)
      check("stall_stable", {rd_if.rd_last, rd_if.rd_data}, prev_word);
    prev_stall = rd_if.rd_valid && !rd_ready;
    prev_word  = {rd_if.rd_last, rd_if.rd_data};
    if (rd_if.rd_valid && rd_ready)
      mon_q.push_back({rd_if.rd_last, rd_if.rd_data});
    if (sat_if.rd_valid && rd_ready)
      sat_q.push_back({sat_if.rd_last, sat_if.rd_data});
  end

  always @(posedge clk50) begin
    if (rand_en) begin
      #2;
      if (rand_en) rd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic pulse_in(input int ch, input int n);
    repeat (n) begin
      inpulse[ch] = 1'b1;
      step(2);
      inpulse[ch] = 1'b0;
      step(2);
    end
  endtask

  task automatic pulse_stim(input int n);
    repeat (n) begin
      stim_pulse = 1'b1;
      step(2);
      stim_pulse = 1'b0;
      step(2);
    end
  endtask

  task automatic start_win(input int len, input logic cont);
    win_len   = WIN_W'(len);
    cont_mode = cont;
    cnt_start = 1'b1;
    step(1);
    cnt_start = 1'b0;
  endtask

  task automatic push_frame(input int c0, input int c1, input int c2, input int c3);
    exp_q.push_back({1'b0, HDR0_DEF});
    exp_q.push_back({1'b0, HDR1_DEF});
    exp_q.push_back({1'b0, 10'(c0)});
    exp_q.push_back({1'b0, 10'(c1)});
    exp_q.push_back({1'b0, 10'(c2)});
    exp_q.push_back({1'b0, 10'(c3)});
    exp_q.push_back({1'b1, TRL_DEF});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t;
    int base;
    t = 0;
    base = done_cnt;
    while (done_cnt == base && t < budget) begin
      step(1);
      t++;
    end
    check(tag, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int t;
    int n;
    logic [CNT_W:0] e;
    t = 0;
    while (mon_q.size() < exp_q.size() && t < 3000) begin
      step(1);
      t++;
    end
    check({tag, "_len"}, mon_q.size(), exp_q.size());
    n = 0;
    while (exp_q.size() > 0 && mon_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_w%0d", tag, n), mon_q.pop_front(), e);
      n++;
    end
    exp_q.delete();
    step(3);
    check({tag, "_extra"}, mon_q.size(), 0);
    mon_q.delete();
  endtask

  initial begin
    int d0;
    rst = 1'b1; inpulse = '0; stim_pulse = 1'b0; stim_mask = '0;
    cnt_start = 1'b0; cnt_clr = 1'b0; cont_mode = 1'b0; win_len = '0;
    rd_ready = 1'b1;
    step(3);
    check("rst_busy", cnt_busy, 0);
    check("rst_done", cnt_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_valid", rd_if.rd_valid, 0);
    check("rst_last", rd_if.rd_last, 0);
    check("rst_data", rd_if.rd_data, 0);
    rst = 1'b0;
    step(2);

    // Single window, 7 pulses on ch2
    d0 = done_cnt;
    start_win(100, 1'b0);
    step(1);
    check("t1_busy", cnt_busy, 1);
    pulse_in(2, 7);
    push_frame(0, 0, 7, 0);
    wait_done("t1_done", 200);
    check_frame("t1");
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_busy_at_done", done_busy, 0);

    // Saturation: 20 edges on ch0
    sat_q.delete();
    start_win(200, 1'b0);
    pulse_in(0, 20);
    push_frame(20, 0, 0, 0);
    wait_done("t2_done", 400);
    check_frame("t2");
    check("t2_sat_len", sat_q.size(), 7);
    if (sat_q.size() == 7) begin
      check("t2_sat_hdr0", sat_q[0], {1'b0, 4'hE});
      check("t2_sat_ch0", sat_q[2], {1'b0, 4'hF});
      check("t2_sat_trl", sat_q[6], {1'b1, 4'hF});
    end

    // win_len = 0 behaves as a 1-cycle window
    start_win(0, 1'b0);
    step(1);
    check("t0_busy_close", cnt_busy, 1);
    step(1);
    check("t0_done", cnt_done, 1);
    check("t0_busy_idle", cnt_busy, 0);
    push_frame(0, 0, 0, 0);
    check_frame("t0");

    // Continuous mode with stalled readout -> overrun
    rd_ready = 1'b0;
    d0 = done_cnt;
    inpulse[1] = 1'b1;
    start_win(10, 1'b1);
    step(2);
    inpulse[1] = 1'b0;
    step(25);
    check("t3_overrun", overrun, 1);
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_valid", rd_if.rd_valid, 1);
    check("t3_hdr0_held", rd_if.rd_data, HDR0_DEF);
    cont_mode = 1'b0;
    step(20);
    check("t3_busy_idle", cnt_busy, 0);
    check("t3_done_still", done_cnt - d0, 1);
    push_frame(0, 1, 0, 0);
    rd_ready = 1'b1;
    check_frame("t3");

    // cnt_clr mid-window with an edge in flight, then restart
    start_win(60, 1'b0);
    pulse_in(3, 3);
    inpulse[3] = 1'b1;
    step(1);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    inpulse[3] = 1'b0;
    check("t4_busy", cnt_busy, 0);
    check("t4_overrun_clr", overrun, 0);
    d0 = done_cnt;
    step(10);
    cnt_clr = 1'b1; cnt_start = 1'b1;
    step(1);
    cnt_clr = 1'b0; cnt_start = 1'b0;
    check("t4_clr_wins", cnt_busy, 0);
    check("t4_no_frame", mon_q.size() + (done_cnt - d0), 0);
    start_win(60, 1'b0);
    pulse_in(0, 2);
    push_frame(2, 0, 0, 0);
    wait_done("t4_done", 200);
    check_frame("t4");
    check("t4_done_cnt", done_cnt - d0, 1);

    // Stimulus pulses through the mask
    stim_mask = 4'b1010;
    start_win(100, 1'b0);
    pulse_stim(5);
    push_frame(0, 5, 0, 5);
    wait_done("t5_done", 200);
    check_frame("t5");
    stim_mask = '0;

    // Random backpressure during a frame
    rand_en = 1'b1;
    start_win(50, 1'b0);
    pulse_in(0, 3);
    pulse_in(2, 1);
    push_frame(3, 0, 1, 0);
    wait_done("t6_done", 200);
    check_frame("t6");
    rand_en = 1'b0;
    rd_ready = 1'b1;
    step(2);

    // Reset in the middle of a stalled frame
    rd_ready = 1'b0;
    start_win(10, 1'b1);
    step(28);
    check("t7_pre_valid", rd_if.rd_valid, 1);
    check("t7_pre_overrun", overrun, 1);
    rst = 1'b1;
    step(1);
    check("t7_busy", cnt_busy, 0);
    check("t7_done", cnt_done, 0);
    check("t7_overrun", overrun, 0);
    check("t7_valid", rd_if.rd_valid, 0);
    check("t7_last", rd_if.rd_last, 0);
    check("t7_data", rd_if.rd_data, 0);
    rst = 1'b0;
    cont_mode = 1'b0;
    rd_ready = 1'b1;
    step(5);
    check("t7_quiet", mon_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
